// File: rtl/spi_mem_master.sv
// SPI master for serial RAM: single 8/16-bit read or write per request, SPI mode 0.
// Frame is opcode, 24-bit address, then 8 or 16 data bits, all MSB first.
module spi_mem_master #(
    parameter int unsigned DIV       = 1,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        spi_select,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [7:0] DivLast = 8'(DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        phase_q, phase_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [47:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;

    logic accept;
    logic phase_end;
    logic last_bit;

    assign accept    = req_valid && (state_q == StIdle);
    assign phase_end = (state_q == StShift) && (div_cnt_q == DivLast);
    assign last_bit  = bit_cnt_q == (byte_q ? 6'd39 : 6'd47);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = StShift;
            StShift: if (phase_end && phase_q && last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            write_q   <= 1'b0;
            byte_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            write_q   <= write_d;
            byte_q    <= byte_d;
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        write_d   = write_q;
        byte_d    = byte_q;
        if (accept) begin
            write_d   = req_write;
            byte_d    = req_byte;
            div_cnt_d = '0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            rx_d      = '0;
            // Byte data sits in the top of the data field so it follows the address directly.
            tx_d = {req_write ? CMD_WRITE : CMD_READ, req_addr,
                    req_write ? (req_byte ? {req_wdata[7:0], 8'h00} : req_wdata) : 16'h0000};
        end else if (state_q == StShift) begin
            if (phase_end) begin
                div_cnt_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // End of high phase: sample MISO and advance MOSI for the next low phase.
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    tx_d      = {tx_q[46:0], 1'b0};
                    if (!write_q) rx_d = {rx_q[14:0], spi_miso};
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        req_ready  = state_q == StIdle;
        busy       = state_q != StIdle;
        spi_select = state_q == StShift;
        spi_clk    = (state_q == StShift) && phase_q;
        spi_mosi   = (state_q == StShift) && tx_q[47];
        rsp_valid  = state_q == StDone;
        rsp_rdata  = 16'h0000;
        if (state_q == StDone && !write_q) begin
            rsp_rdata = byte_q ? {8'h00, rx_q[7:0]} : rx_q;
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: DIV=1 and DIV=3 instances share one serial-RAM responder,
// expectations are queued at request time and matched against completed responses.
module tb_spi_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        sel3 = 1'b0;
    logic        miso = 1'b0;

    always #5 clk = ~clk;

    logic        rv1, rv3;
    logic        ready1, busy1, rspv1, ssel1, sclk1, mosi1;
    logic        ready3, busy3, rspv3, ssel3, sclk3, mosi3;
    logic [15:0] rdata1, rdata3;

    assign rv1 = req_valid && !sel3;
    assign rv3 = req_valid && sel3;

    spi_mem_master #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(ready1), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv1),
        .rsp_rdata(rdata1), .busy(busy1), .spi_select(ssel1), .spi_clk(sclk1),
        .spi_mosi(mosi1), .spi_miso(miso)
    );

    spi_mem_master #(.DIV(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(ready3), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv3),
        .rsp_rdata(rdata3), .busy(busy3), .spi_select(ssel3), .spi_clk(sclk3),
        .spi_mosi(mosi3), .spi_miso(miso)
    );

    logic        m_ready, m_busy, m_rsp, m_sel, m_sclk, m_mosi;
    logic [15:0] m_rdata;
    int          cur_div;

    assign m_ready = sel3 ? ready3 : ready1;
    assign m_busy  = sel3 ? busy3 : busy1;
    assign m_rsp   = sel3 ? rspv3 : rspv1;
    assign m_rdata = sel3 ? rdata3 : rdata1;
    assign m_sel   = sel3 ? ssel3 : ssel1;
    assign m_sclk  = sel3 ? sclk3 : sclk1;
    assign m_mosi  = sel3 ? mosi3 : mosi1;
    assign cur_div = sel3 ? 3 : 1;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        logic [47:0] frame;
        logic [47:0] mask;
    } exp_t;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        logic [47:0] frame;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    // Serial RAM responder (mode 0): captures MOSI on spi_clk rise, drives MISO after the fall.
    logic [7:0]  mem [0:255];
    logic [47:0] r_frame;
    int          r_cnt;
    logic [7:0]  r_op, r_addr;
    logic        rs_sel, rs_clk;

    initial begin
        int         off;
        int         bitn;
        logic [7:0] ba;
        rs_sel = 1'b0; rs_clk = 1'b0; r_cnt = 0; r_frame = '0; r_op = '0; r_addr = '0;
        forever begin
            @(m_sel or m_sclk);
            if (m_sel && !rs_sel) begin
                r_cnt = 0; r_frame = '0; r_op = '0; miso = 1'b0;
            end else if (m_sclk && !rs_clk) begin
                r_frame = {r_frame[46:0], m_mosi};
                r_cnt++;
                if (r_cnt == 32) begin
                    r_op = r_frame[31:24];
                    r_addr = r_frame[7:0];
                end
                if (r_op == 8'h02 && r_cnt == 40) mem[r_addr] = r_frame[7:0];
                if (r_op == 8'h02 && r_cnt == 48) mem[r_addr + 8'd1] = r_frame[7:0];
            end else if (!m_sclk && rs_clk) begin
                if (r_cnt >= 32 && r_op == 8'h03) begin
                    off  = r_cnt - 32;
                    ba   = r_addr + 8'(off / 8);
                    bitn = 7 - (off % 8);
                    miso = mem[ba][bitn];
                end else begin
                    miso = 1'b0;
                end
            end
            rs_sel = m_sel;
            rs_clk = m_sclk;
        end
    end

    // Bus monitor: frame latency, pulse counts and SPI timing rule violations.
    int   lat_cnt = 0, run_len = 0;
    int   rsp_pulses = 0, sel_rises = 0, rsp_long = 0;
    int   mosi_viol = 0, unsel_mosi = 0, phase_viol = 0;
    logic sel_p = 1'b0, sclk_p = 1'b0, mosi_p = 1'b0, rsp_p = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_sel) begin
                if (!sel_p) begin
                    lat_cnt = 1; run_len = 1; sel_rises++;
                end else begin
                    lat_cnt++;
                    if (m_sclk == sclk_p) begin
                        run_len++;
                    end else begin
                        if (run_len != cur_div) phase_viol++;
                        run_len = 1;
                    end
                    if (m_mosi !== mosi_p && !(sclk_p && !m_sclk)) mosi_viol++;
                end
            end else if (m_mosi !== 1'b0) begin
                unsel_mosi++;
            end
            if (m_rsp) begin
                if (rsp_p) rsp_long++;
                else begin
                    rsp_pulses++;
                    obs_q.push_back('{m_rdata, lat_cnt, r_frame});
                end
            end
            sel_p = m_sel; sclk_p = m_sclk; mosi_p = m_mosi; rsp_p = m_rsp;
        end
    end

    task automatic push_exp(input logic d3, input logic w, input logic b, input logic [23:0] a,
                            input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t       e;
        logic [7:0] op;
        int         nbits;
        op = w ? 8'h02 : 8'h03;
        if (b) begin
            e.frame = {8'h00, op, a, w ? wd[7:0] : 8'h00};
            e.mask  = w ? 48'h00FF_FFFF_FFFF : 48'h00FF_FFFF_FF00;
            nbits   = 40;
        end else begin
            e.frame = {op, a, w ? wd : 16'h0000};
            e.mask  = w ? 48'hFFFF_FFFF_FFFF : 48'hFFFF_FFFF_0000;
            nbits   = 48;
        end
        e.rdata = exp_rd;
        e.lat   = 2 * (d3 ? 3 : 1) * nbits;
        exp_q.push_back(e);
    endtask

    // Issue one request from idle; inputs are scrambled right after acceptance.
    task automatic drive_req(input logic d3, input logic w, input logic b, input logic [23:0] a,
                             input logic [15:0] wd, input logic [15:0] exp_rd,
                             input logic do_push);
        @(negedge clk);
        sel3 = d3; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        if (do_push) push_exp(d3, w, b, a, wd, exp_rd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
        req_wdata = 16'($urandom);
        req_write = 1'($urandom);
        req_byte  = 1'($urandom);
    endtask

    task automatic check_rsp(input string name);
        exp_t e;
        obs_t o;
        for (int i = 0; i < 2000 && obs_q.size() == 0; i++) @(negedge clk);
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL %s timeout: got no rsp_valid, want one", name);
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            void'(obs_q.pop_front());
            $display("FAIL %s unexpected rsp: got rsp_valid, want none", name);
            return;
        end
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, o.rdata, e.rdata);
        end
        checks++;
        if (o.lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, o.lat, e.lat);
        end
        checks++;
        if ((o.frame & e.mask) !== (e.frame & e.mask)) begin
            errors++;
            $display("FAIL %s mosi frame: got %h want %h", name, o.frame & e.mask,
                     e.frame & e.mask);
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({ready1, busy1, rspv1, rdata1, ssel1, sclk1, mosi1} !== {1'b1, 1'b0, 1'b0, 16'h0,
                                                                     1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1: got %b want %b", {ready1, busy1, rspv1, rdata1, ssel1,
                     sclk1, mosi1}, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        end
        checks++;
        if ({ready3, busy3, rspv3, rdata3, ssel3, sclk3, mosi3} !== {1'b1, 1'b0, 1'b0, 16'h0,
                                                                     1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut3: got %b want %b", {ready3, busy3, rspv3, rdata3, ssel3,
                     sclk3, mosi3}, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        sel3 = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 24'h000010;
        req_valid = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, 24'h000010, 16'h0, 16'hBEEF);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m_sel !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_accept: got spi_select=%b want 1", m_sel);
        end
        req_valid = 1'b0;
        req_addr  = 24'hFFFFFF;
        check_rsp("word_read_0x10");
    endtask

    task automatic test_word_write();
        drive_req(1'b0, 1'b1, 1'b0, 24'h000020, 16'h1234, 16'h0000, 1'b1);
        check_rsp("word_write_0x20");
        checks++;
        if ({mem[8'h20], mem[8'h21]} !== 16'h1234) begin
            errors++;
            $display("FAIL word_write_mem: got %h want 1234", {mem[8'h20], mem[8'h21]});
        end
    endtask

    task automatic test_byte_read();
        drive_req(1'b0, 1'b0, 1'b1, 24'h000021, 16'h0, 16'h0034, 1'b1);
        check_rsp("byte_read_0x21");
    endtask

    task automatic test_byte_write();
        drive_req(1'b0, 1'b1, 1'b1, 24'h000050, 16'hABCD, 16'h0000, 1'b1);
        check_rsp("byte_write_0x50");
        checks++;
        if ({mem[8'h50], mem[8'h51]} !== 16'hCD77) begin
            errors++;
            $display("FAIL byte_write_mem: got %h want cd77", {mem[8'h50], mem[8'h51]});
        end
    endtask

    task automatic test_word_read();
        drive_req(1'b0, 1'b0, 1'b0, 24'h000030, 16'h0, 16'hA55A, 1'b1);
        check_rsp("word_read_0x30");
    endtask

    task automatic test_div3();
        drive_req(1'b1, 1'b0, 1'b0, 24'h000010, 16'h0, 16'hBEEF, 1'b1);
        check_rsp("div3_word_read");
        @(negedge clk);
        sel3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base_sel;
        int base_rsp;
        base_sel = sel_rises;
        base_rsp = rsp_pulses;
        @(negedge clk);
        sel3 = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 24'h000010;
        req_valid = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, 24'h000010, 16'h0, 16'hBEEF);
        for (int i = 0; i < 50 && sel_rises < base_sel + 1; i++) @(negedge clk);
        req_addr = 24'h000030;
        push_exp(1'b0, 1'b0, 1'b0, 24'h000030, 16'h0, 16'hA55A);
        for (int i = 0; i < 300 && sel_rises < base_sel + 2; i++) @(negedge clk);
        req_valid = 1'b0;
        check_rsp("b2b_first");
        check_rsp("b2b_second");
        repeat (10) @(negedge clk);
        checks++;
        if (sel_rises - base_sel !== 2) begin
            errors++;
            $display("FAIL b2b_frames: got %0d want 2", sel_rises - base_sel);
        end
        checks++;
        if (rsp_pulses - base_rsp !== 2) begin
            errors++;
            $display("FAIL b2b_rsp_pulses: got %0d want 2", rsp_pulses - base_rsp);
        end
    endtask

    task automatic test_reset_midframe();
        int base_rsp;
        base_rsp = rsp_pulses;
        drive_req(1'b0, 1'b1, 1'b0, 24'h000040, 16'h9999, 16'h0000, 1'b0);
        for (int i = 0; i < 500 && r_cnt < 20; i++) @(negedge clk);
        checks++;
        if (r_cnt < 20) begin
            errors++;
            $display("FAIL midframe_reach_bit20: got %0d bits want 20", r_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_sel, m_sclk, m_mosi, m_rsp, m_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %b want 00001",
                     {m_sel, m_sclk, m_mosi, m_rsp, m_ready});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rsp_pulses !== base_rsp || obs_q.size() != 0) begin
            errors++;
            $display("FAIL midframe_no_rsp: got %0d pulses want 0", rsp_pulses - base_rsp);
        end
        checks++;
        if ({mem[8'h40], mem[8'h41]} !== 16'h0000) begin
            errors++;
            $display("FAIL midframe_mem: got %h want 0000", {mem[8'h40], mem[8'h41]});
        end
        drive_req(1'b0, 1'b0, 1'b0, 24'h000010, 16'h0, 16'hBEEF, 1'b1);
        check_rsp("read_after_reset");
    endtask

    task automatic test_protocol();
        checks++;
        if (mosi_viol !== 0) begin
            errors++;
            $display("FAIL mosi_change_timing: got %0d violations want 0", mosi_viol);
        end
        checks++;
        if (unsel_mosi !== 0) begin
            errors++;
            $display("FAIL mosi_when_deselected: got %0d cycles want 0", unsel_mosi);
        end
        checks++;
        if (phase_viol !== 0) begin
            errors++;
            $display("FAIL spi_clk_phase_width: got %0d violations want 0", phase_viol);
        end
        checks++;
        if (rsp_long !== 0) begin
            errors++;
            $display("FAIL rsp_valid_width: got %0d extra cycles want 0", rsp_long);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hBE; mem[8'h11] = 8'hEF;
        mem[8'h30] = 8'hA5; mem[8'h31] = 8'h5A;
        mem[8'h51] = 8'h77;
        test_reset();
        test_word_write();
        test_byte_read();
        test_byte_write();
        test_word_read();
        test_div3();
        test_back_to_back();
        test_reset_midframe();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
